param_alu_seq: RTL and testbench

- Parametrised, registered successor to the data-path ALU.
- Generic WIDTH operand path with correct signed-overflow flags and barrel shifts by a variable amount.
- Adds multi-cycle unsigned multiply and divide behind a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux; the control unit issues one operation at a time.

---
 rtl/param_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_param_alu_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu_seq.sv
// param_alu_seq: registered ALU. Ops 0-11 complete in one cycle; MUL/MULH iterate WIDTH cycles.
// Define PARAM_ALU_SEQ_DIV_EN to build the restoring divider behind DIVU/REMU (ops 14/15).
module param_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_C,
    output logic             o_N,
    output logic             o_V,
    output logic             o_Z,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_MULH = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_result;
    logic               r_C;
    logic               r_N;
    logic               r_V;
    logic               r_Z;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_aluRes;
    logic               w_aluC;
    logic               w_aluV;
    logic [WIDTH:0]     w_addSum;
    logic [WIDTH:0]     w_subDiff;
    logic [WIDTH:0]     w_lsl;
    logic [WIDTH:0]     w_lsr;
    logic [WIDTH:0]     w_asr;
    logic [SHW-1:0]     w_sh;
    logic               w_isMul;
    logic               w_lastIter;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_prodNext;
    logic [WIDTH-1:0]   w_finRes;
    logic               w_finC;
    logic               w_finV;

`ifdef PARAM_ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               w_isDiv;
    logic [WIDTH:0]     w_divShift;
    logic               w_divGe;
    logic [WIDTH-1:0]   w_divDiff;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quotNext;
`endif

    assign o_result = r_result;
    assign o_C      = r_C;
    assign o_N      = r_N;
    assign o_V      = r_V;
    assign o_Z      = r_Z;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    // Subtraction is a + ~b + carry-in, so the carry-out is directly NOT borrow.
    assign w_sh      = i_b[SHW-1:0];
    assign w_addSum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, (i_op == OP_ADDC) & i_cin};
    assign w_subDiff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, (i_op == OP_SUBC) ? i_cin : 1'b1};
    assign w_lsl     = {1'b0, i_a} << w_sh;
    assign w_lsr     = {i_a, 1'b0} >> w_sh;
    assign w_asr     = $signed({i_a, 1'b0}) >>> w_sh;
    assign w_isMul   = (i_op == OP_MUL) || (i_op == OP_MULH);

    always_comb begin
        w_aluRes = '0;
        w_aluC   = 1'b0;
        w_aluV   = 1'b0;
        case (i_op)
            OP_ADD, OP_ADDC: begin
                w_aluRes = w_addSum[WIDTH-1:0];
                w_aluC   = w_addSum[WIDTH];
                w_aluV   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_addSum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                w_aluRes = w_subDiff[WIDTH-1:0];
                w_aluC   = w_subDiff[WIDTH];
                w_aluV   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_subDiff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:   w_aluRes = i_a & i_b;
            OP_OR:    w_aluRes = i_a | i_b;
            OP_XOR:   w_aluRes = i_a ^ i_b;
            OP_NOTA:  w_aluRes = ~i_a;
            OP_LSL: begin
                w_aluRes = w_lsl[WIDTH-1:0];
                w_aluC   = w_lsl[WIDTH];
            end
            OP_LSR: begin
                w_aluRes = w_lsr[WIDTH:1];
                w_aluC   = w_lsr[0];
            end
            OP_ASR: begin
                w_aluRes = w_asr[WIDTH:1];
                w_aluC   = w_asr[0];
            end
            OP_PASSB: w_aluRes = i_b;
`ifndef PARAM_ALU_SEQ_DIV_EN
            OP_DIVU, OP_REMU: w_aluV = 1'b1;
`endif
            default: ;
        endcase
    end

    // Shift-add multiply: the multiplier sits in the low half and is consumed one bit per cycle.
    assign w_mulSum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prodNext = {w_mulSum, r_prod[WIDTH-1:1]};
    assign w_lastIter = ((r_state == MULT) || (r_state == DIV)) && (r_cnt == LAST_ITER);

`ifdef PARAM_ALU_SEQ_DIV_EN
    assign w_isDiv    = (i_op == OP_DIVU) || (i_op == OP_REMU);
    assign w_divShift = {r_rem, r_quot[WIDTH-1]};
    assign w_divGe    = w_divShift >= {1'b0, r_b};
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_b;
    assign w_remNext  = w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
    assign w_quotNext = {r_quot[WIDTH-2:0], w_divGe};
`endif

    // The final iteration's result goes straight to the outputs so done lands in the FIN cycle.
    always_comb begin
        w_finRes = w_prodNext[WIDTH-1:0];
        w_finC   = 1'b0;
        w_finV   = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_finC = |w_prodNext[2*WIDTH-1:WIDTH];
                w_finV = |w_prodNext[2*WIDTH-1:WIDTH];
            end
            OP_MULH: w_finRes = w_prodNext[2*WIDTH-1:WIDTH];
`ifdef PARAM_ALU_SEQ_DIV_EN
            OP_DIVU: begin
                w_finRes = (r_b == '0) ? '1 : w_quotNext;
                w_finV   = (r_b == '0);
            end
            OP_REMU: begin
                w_finRes = (r_b == '0) ? r_a : w_remNext;
                w_finV   = (r_b == '0);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start && w_isMul) begin
                    w_nextState = MULT;
                end
`ifdef PARAM_ALU_SEQ_DIV_EN
                else if (i_start && w_isDiv) begin
                    w_nextState = DIV;
                end
`endif
            end
            MULT, DIV: begin
                if (r_cnt == LAST_ITER) begin
                    w_nextState = FIN;
                end
            end
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_result <= '0;
            r_C      <= 1'b0;
            r_N      <= 1'b0;
            r_V      <= 1'b0;
            r_Z      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef PARAM_ALU_SEQ_DIV_EN
            r_b      <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op   <= i_op;
                        r_a    <= i_a;
                        r_cnt  <= '0;
                        r_prod <= {{WIDTH{1'b0}}, i_b};
`ifdef PARAM_ALU_SEQ_DIV_EN
                        r_b    <= i_b;
                        r_rem  <= '0;
                        r_quot <= i_a;
`endif
                        if (w_nextState == IDLE) begin
                            r_result <= w_aluRes;
                            r_C      <= w_aluC;
                            r_V      <= w_aluV;
                            r_N      <= w_aluRes[WIDTH-1];
                            r_Z      <= (w_aluRes == '0);
                            r_done   <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_prod <= w_prodNext;
                end
`ifdef PARAM_ALU_SEQ_DIV_EN
                DIV: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                end
`endif
                default: ;
            endcase
            if (w_lastIter) begin
                r_result <= w_finRes;
                r_C      <= w_finC;
                r_V      <= w_finV;
                r_N      <= w_finRes[WIDTH-1];
                r_Z      <= (w_finRes == '0);
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_alu_seq.sv
// tb_param_alu_seq: scoreboard bench for param_alu_seq at WIDTH=32, directed steps plus random single-cycle ops.
// Follows PARAM_ALU_SEQ_DIV_EN so ops 14/15 are checked against whichever build is compiled.
`timescale 1ns/1ps
module tb_param_alu_seq;

    localparam int W = 32;

    typedef struct {
        string        tag;
        logic [W-1:0] result;
        logic         c;
        logic         n;
        logic         v;
        logic         z;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic [W-1:0] result;
    logic         flagC;
    logic         flagN;
    logic         flagV;
    logic         flagZ;
    logic         busy;
    logic         done;

    int   nAsserts = 0;
    int   nFails   = 0;
    exp_t q[$];

    param_alu_seq #(.WIDTH(W)) dut (
        .i_clk    (clock),
        .i_reset  (reset),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_cin    (cin),
        .o_result (result),
        .o_C      (flagC),
        .o_N      (flagN),
        .o_V      (flagV),
        .o_Z      (flagZ),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, required finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(input string tag, input logic [W-1:0] r, input logic c,
                                   input logic n, input logic v, input logic z);
        exp_t e;
        e.tag    = tag;
        e.result = r;
        e.c      = c;
        e.n      = n;
        e.v      = v;
        e.z      = z;
        return e;
    endfunction

    // Reference behaviour uses 64-bit exact arithmetic; overflow is "exact result differs from wrapped".
    function automatic exp_t modelAlu(input logic [3:0] mop, input logic [W-1:0] ma,
                                      input logic [W-1:0] mb, input logic mcin);
        exp_t        e;
        logic [63:0] wide;
        logic        bin;
        longint      exact;
        int          sh;
        e  = mkExp("rand_op", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        sh = int'(mb[4:0]);
        case (mop)
            4'd0, 4'd1: begin
                bin      = (mop == 4'd1) && mcin;
                wide     = {32'b0, ma} + {32'b0, mb} + {63'b0, bin};
                e.result = wide[31:0];
                e.c      = wide[32];
                exact    = longint'($signed(ma)) + longint'($signed(mb)) + longint'(bin);
                e.v      = exact != longint'($signed(e.result));
            end
            4'd2, 4'd3: begin
                bin      = (mop == 4'd3) ? ~mcin : 1'b0;
                e.result = ma - mb - {31'b0, bin};
                e.c      = {32'b0, ma} >= ({32'b0, mb} + {63'b0, bin});
                exact    = longint'($signed(ma)) - longint'($signed(mb)) - longint'(bin);
                e.v      = exact != longint'($signed(e.result));
            end
            4'd4: e.result = ma & mb;
            4'd5: e.result = ma | mb;
            4'd6: e.result = ma ^ mb;
            4'd7: e.result = ~ma;
            4'd8: begin
                e.result = ma << sh;
                e.c      = (sh == 0) ? 1'b0 : ma[32-sh];
            end
            4'd9: begin
                e.result = ma >> sh;
                e.c      = (sh == 0) ? 1'b0 : ma[sh-1];
            end
            4'd10: begin
                e.result = $signed(ma) >>> sh;
                e.c      = (sh == 0) ? 1'b0 : ma[sh-1];
            end
            default: e.result = mb;
        endcase
        e.z = (e.result == '0);
        e.n = e.result[W-1];
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        nAsserts++;
        assert (q.size() != 0) else begin
            nFails++;
            $error("[TB] FAIL unexpected_done: observed done=1 result=%h, expected no pending op", result);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            nAsserts++;
            assert ({result, flagC, flagN, flagV, flagZ} === {e.result, e.c, e.n, e.v, e.z}) else begin
                nFails++;
                $error("[TB] FAIL %s: observed result=%h CNVZ=%b%b%b%b, expected result=%h CNVZ=%b%b%b%b",
                       e.tag, result, flagC, flagN, flagV, flagZ, e.result, e.c, e.n, e.v, e.z);
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clock);
        if (done) checkOutput();
    endtask

    task automatic applyStimulus(input logic [3:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb,
                                 input logic scin, input exp_t e);
        op    = sop;
        a     = sa;
        b     = sb;
        cin   = scin;
        start = 1'b1;
        q.push_back(e);
        stepCycle();
        start = 1'b0;
    endtask

    // Issues a multi-cycle op, optionally pokes a conflicting start mid-way, and checks busy/done timing.
    task automatic runMulti(input logic [3:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb,
                            input exp_t e, input bit poke);
        int cyc;
        int busyCycles;
        applyStimulus(sop, sa, sb, 1'b0, e);
        cyc        = 1;
        busyCycles = 0;
        while (!done && cyc < 200) begin
            if (busy) busyCycles++;
            if (poke && cyc == 6) begin
                start = 1'b1;
                op    = 4'd0;
                a     = 32'h1234_5678;
                b     = 32'h0F0F_0F0F;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (done) begin
            checkVal({e.tag, "_busyAtDone"}, 64'(busy), 64'd0);
            checkOutput();
        end else begin
            q.delete();
        end
        checkVal({e.tag, "_latency"}, 64'(cyc), 64'd33);
        checkVal({e.tag, "_busyCycles"}, 64'(busyCycles), 64'd32);
        stepCycle();
    endtask

    initial begin
        #1;
        checkVal("resetState", 64'({result, flagC, flagN, flagV, flagZ, busy, done}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        stepCycle();
        checkVal("idleAfterReset", 64'({busy, done}), 64'd0);

        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, mkExp("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0));
        applyStimulus(4'd2, 32'd5, 32'd5, 1'b0, mkExp("sub_eq", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
        applyStimulus(4'd2, 32'd3, 32'd5, 1'b0, mkExp("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(4'd10, 32'h8000_0010, 32'd4, 1'b0, mkExp("asr4", 32'hF800_0001, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(4'd8, 32'h8000_0001, 32'd1, 1'b0, mkExp("lsl1", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0));
        checkVal("burstLatency", 64'(q.size()), 64'd0);
        repeat (3) stepCycle();
        checkVal("donePulse", 64'(done), 64'd0);
        checkVal("holdResult", 64'({result, flagC}), 64'({32'h0000_0002, 1'b1}));

        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, mkExp("addc_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
        applyStimulus(4'd3, 32'h0, 32'h0, 1'b0, mkExp("subc_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(4'd2, 32'h8000_0000, 32'h1, 1'b0, mkExp("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0));
        applyStimulus(4'd9, 32'h8000_0001, 32'h20, 1'b0, mkExp("lsr_amt0", 32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(4'd9, 32'hC000_0000, 32'd31, 1'b0, mkExp("lsr31", 32'h1, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(4'd7, 32'h0, 32'h0, 1'b0, mkExp("nota", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(4'd11, 32'h5, 32'h0, 1'b0, mkExp("passb0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        checkVal("directedLatency", 64'(q.size()), 64'd0);
        stepCycle();

        runMulti(4'd12, 32'h0001_0000, 32'h0001_0000, mkExp("mul", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
        runMulti(4'd13, 32'h0001_0000, 32'h0001_0000, mkExp("mulh_poke", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        runMulti(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mkExp("mul_max", 32'h1, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);

`ifdef PARAM_ALU_SEQ_DIV_EN
        runMulti(4'd14, 32'd100, 32'd7, mkExp("divu", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        runMulti(4'd15, 32'd100, 32'd7, mkExp("remu", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        runMulti(4'd14, 32'd100, 32'd0, mkExp("divu_by0", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0);
        runMulti(4'd15, 32'd100, 32'd0, mkExp("remu_by0", 32'd100, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
`else
        applyStimulus(4'd14, 32'd100, 32'd7, 1'b0, mkExp("divu_off", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
        checkVal("divuOffBusy", 64'(busy), 64'd0);
        applyStimulus(4'd15, 32'd100, 32'd0, 1'b0, mkExp("remu_off", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
        checkVal("remuOffBusy", 64'(busy), 64'd0);
        checkVal("divOffLatency", 64'(q.size()), 64'd0);
        stepCycle();
`endif

        for (int i = 0; i < 16; i++) begin
            logic [3:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            rop = 4'($urandom_range(0, 11));
            ra  = $urandom;
            rb  = $urandom;
            rc  = 1'($urandom_range(0, 1));
            applyStimulus(rop, ra, rb, rc, modelAlu(rop, ra, rb, rc));
        end
        checkVal("randomLatency", 64'(q.size()), 64'd0);
        stepCycle();

        applyStimulus(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b0, mkExp("mul_aborted", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1));
        repeat (9) stepCycle();
        reset = 1'b1;
        #1;
        checkVal("abortOutputs", 64'({result, flagC, flagN, flagV, flagZ, busy, done}), 64'd0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (40) stepCycle();
        checkVal("abortNoBusy", 64'({busy, done}), 64'd0);

        applyStimulus(4'd0, 32'd2, 32'd3, 1'b0, mkExp("add_after_reset", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0));
        checkVal("postResetLatency", 64'(q.size()), 64'd0);
        repeat (2) stepCycle();
        checkVal("queueEmpty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
